// File: rtl/iob_native_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : iob_native_mem_responder
// Purpose  : Byte-enabled word memory behind the native cache memory port,
//            with fixed latency, optional LFSR wait states and access counters.
// Revision : 1.0
// ============================================================================
module iob_native_mem_responder #(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter int         MEM_ADDR_W = 10,
    parameter int         LATENCY    = 1,
    parameter int         STALL_EN   = 0,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic [31:0]         n_reads,
    output logic [31:0]         n_writes
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int DEPTH  = 1 << MEM_ADDR_W;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              lfsr_q;
    logic [MEM_ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic [DATA_W-1:0]       rdata_q;
    logic [31:0]             n_reads_q, n_writes_q;
    logic [DATA_W-1:0]       mem_q [0:DEPTH-1];

    logic [CNT_W-1:0]        extra;
    logic [CNT_W-1:0]        load_cnt;
    logic                    enter_resp;
    logic                    unused_addr_bits;

    assign extra    = (STALL_EN != 0) ? CNT_W'(lfsr_q[1:0]) : '0;
    assign load_cnt = CNT_W'(LATENCY) + extra;

    // Upper address bits alias and byte-offset bits are don't-care.
    assign unused_addr_bits = ^addr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    idx_d   = addr[MEM_ADDR_W+OFF_W-1:OFF_W];
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    cnt_d   = load_cnt;
                    state_d = (load_cnt == '0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The array is touched on the edge that enters RESP; with zero latency
    // that is the accept edge itself, hence the use of the _d copies.
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            idx_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            n_reads_q  <= '0;
            n_writes_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (enter_resp && (wstrb_d == '0)) begin
                rdata_q <= mem_q[idx_d];
            end
            if (state_q == S_RESP) begin
                if (wstrb_q != '0) begin
                    n_writes_q <= n_writes_q + 32'd1;
                end else begin
                    n_reads_q <= n_reads_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && enter_resp) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_d[b]) begin
                    mem_q[idx_d][b*8 +: 8] <= wdata_d[b*8 +: 8];
                end
            end
        end
    end

    assign rdata    = rdata_q;
    assign ready    = (state_q == S_RESP);
    assign n_reads  = n_reads_q;
    assign n_writes = n_writes_q;

endmodule
`default_nettype wire

// File: doc/iob_native_mem_responder.md
# iob_native_mem_responder

Back-end responder for the native memory interface driven by the cache (`mem_valid`/`mem_addr`/`mem_wdata`/`mem_wstrb` → `mem_rdata`/`mem_ready`). It replaces the zero-wait RAM in cache benches and small SoC builds with a byte-enabled word memory. It adds programmable fixed latency and optional pseudo-random extra wait states, so the cache's refill, write-through and stall paths are exercised. It also exposes read and write access counters for bench checking.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width of `addr`.
- `DATA_W`, 32, data width; must be a multiple of 8.
- `MEM_ADDR_W`, 10, log2 of memory depth in words.
- `LATENCY`, 1, fixed wait cycles between accept and `ready` (0..15).
- `STALL_EN`, 0, 1 adds 0..3 LFSR-driven extra wait cycles per access.
- `LFSR_SEED`, 8'hA5, non-zero LFSR reset value.

Ports:
- `clk`, in, 1, clock.
- `reset`, in, 1, reset: asynchronous, active-high.
- `valid`, in, 1, request valid; held by the requester until `ready`.
- `addr`, in, ADDR_W, byte address.
- `wdata`, in, DATA_W, write data.
- `wstrb`, in, DATA_W/8, byte enables; non-zero means write, zero means read.
- `rdata`, out, DATA_W, read data.
- `ready`, out, 1, one-cycle completion pulse.
- `n_reads`, out, 32, completed reads.
- `n_writes`, out, 32, completed writes.

## Operation
- The FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - If `valid` is high, latch `addr`, `wdata` and `wstrb`, then load the wait counter with LATENCY + extra.
  - extra = `lfsr[1:0]` when STALL_EN = 1, else 0.
  - Go to RESP if the loaded count is 0, else go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - Go to RESP on the cycle the counter reaches 0.
- RESP:
  - `ready` = 1 for this cycle only. Return to IDLE.
- Memory access happens on the clock edge that enters RESP.
  - Write: update only the bytes whose `wstrb` bit is set.
  - Read: `rdata` is loaded from the array.
- `rdata` holds the last read value until the next read completes. Writes do not change `rdata`.
- A read returns every write completed before it, including a write to the same word completed on the immediately preceding access.
- Word index = latched `addr[MEM_ADDR_W+log2(DATA_W/8)-1 : log2(DATA_W/8)]`.
  - Upper address bits are ignored, so addresses alias modulo the memory size.
  - Low byte-offset bits are ignored.
- Counters:
  - `n_reads` increments by 1 on each RESP cycle of a read; `n_writes` on each RESP cycle of a write.
  - Both wrap from 2^32-1 to 0.
- LFSR:
  - 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts every cycle outside reset.
  - Sampled only in IDLE on accept.
- Inputs are not re-sampled after accept. A `valid` deassertion or `addr` change during WAIT is a protocol violation; the latched access still completes and `ready` still pulses.
- Memory contents are not initialised or reset; they are X until written.

## Timing
- Reset values:
  - `ready` = 0, `rdata` = 0, `n_reads` = 0, `n_writes` = 0.
  - FSM in IDLE, LFSR = LFSR_SEED, wait counter = 0.
- Latency: `valid` seen high in IDLE at edge N gives `ready` high during cycle N+1+LATENCY(+extra).
  - With LATENCY = 0 and STALL_EN = 0, `ready` is high the cycle after accept.
- `rdata` is valid in the `ready` cycle.
- Back-to-back: after the RESP cycle the FSM is in IDLE. If `valid` is still high, that is a new request and is accepted at the next edge.
  - Minimum spacing between accepts is therefore LATENCY+2 cycles.
  - This supports cache line refills, where `valid` stays high while `addr` advances after each `ready`.
- `ready` is never high for two consecutive cycles.
- Reset asserted mid-WAIT or mid-RESP:
  - Outputs return to reset values immediately; the FSM returns to IDLE.
  - A pending write is dropped if reset arrives before the RESP edge.
  - No counter increments.
- In reset, any `valid` is ignored. The first accept can occur at the first edge after reset deasserts.

## Test plan
- Reset check: hold `reset` for 5 cycles with `valid`=1 → `ready`=0, `rdata`=0, counters 0 throughout. After release, first `ready` at cycle 1+LATENCY+1.
- Write then read, LATENCY=1:
  - Writes of `wdata`=i to words 0..9, `wstrb`=4'hF → each `ready` exactly 2 cycles after accept.
  - Reads of 0..9 → `rdata`=i.
  - `n_writes`=10, `n_reads`=10.
- Byte enables:
  - Write 32'hDEADBEEF to word 5, then 32'h000000AA with `wstrb`=4'b0001 → read gives 32'hDEADBEAA.
  - Then `wstrb`=4'b1000 with 32'h11000000 → read gives 32'h11ADBEAA.
- Aliasing:
  - With MEM_ADDR_W=10, write 32'h12345678 to byte address 0x1004 → read of byte address 0x0004 returns 32'h12345678.
  - Byte address 0x0006 maps to the same word.
- Line refill with STALL_EN=1:
  - Hold `valid` for 8 sequential reads, advancing `addr` after each `ready` → 8 `ready` pulses, correct data in order, never two consecutive `ready` cycles.
  - Accept-to-`ready` gap is within LATENCY+1..LATENCY+4.
- Reset mid-write:
  - LATENCY=4; assert `reset` 2 cycles after accepting a write of 32'hCAFEF00D to word 3, which previously held 32'h0.
  - → no `ready`, `n_writes`=0, and a later read of word 3 returns 32'h0.
